// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and default sizing for the UART receive path
package uart_pkg;

`ifdef FORMAL
  localparam int CLOCKS_PER_BIT_DEF = 8;
`else
  localparam int CLOCKS_PER_BIT_DEF = 5000;
`endif

  localparam int DATA_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// rtl/uart_rx_bit_timer.sv - modulo bit counter producing a registered mid-bit sampling strobe
module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic start_pulse,
  output logic bit_strobe
);

  localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_BIT >> 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;

  // Loading half a period on the start edge puts every later strobe near mid-bit.
  always_comb begin
    cnt_d    = cnt_q;
    strobe_d = (cnt_q == CNT_LAST);
    if (start_pulse) begin
      cnt_d = CNT_HALF;
    end else if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign bit_strobe = strobe_q;

endmodule

// File: rtl/uart_rx_controller.sv
// rtl/uart_rx_controller.sv - UART receive sequencer: sync, start detect, frame FSM, byte handshake
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEF,
  parameter int DATA_BITS      = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 framing_err,
  output logic                 overrun_err
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 start_pulse;
  logic                 bit_strobe;
  logic                 start_edge;

  assign start_edge = rx_prev_q & ~rx_s_q;

  uart_rx_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (state_q != IDLE),
    .start_pulse(start_pulse),
    .bit_strobe (bit_strobe)
  );

  always_comb begin
    rx_meta_d     = rx;
    rx_s_d        = rx_meta_q;
    rx_prev_d     = rx_s_q;
    state_d       = state_q;
    shift_d       = shift_q;
    bit_idx_d     = bit_idx_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q & ~rx_ready;
    framing_err_d = 1'b0;
    overrun_err_d = 1'b0;
    start_pulse   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          start_pulse = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        if (bit_strobe) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (bit_strobe) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == LAST_IDX) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // A bad stop bit wins over overrun: the byte is never offered.
        if (bit_strobe) begin
          state_d = IDLE;
          if (!rx_s_q) begin
            framing_err_d = 1'b1;
          end else if (rx_valid_q && !rx_ready) begin
            overrun_err_d = 1'b1;
          end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      shift_q       <= '0;
      bit_idx_q     <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      rx_prev_q     <= rx_prev_d;
      shift_q       <= shift_d;
      bit_idx_q     <= bit_idx_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q != IDLE);
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb/tb_uart_rx_controller.sv - directed and randomized frames checked against a sampling-schedule model
module tb_uart_rx_controller;

  localparam int CPB     = 8;
  localparam int DB      = 8;
  localparam int S0      = 1 + CPB - CPB / 2;
  localparam int STOP_AT = S0 + CPB * (DB + 1);
  localparam int NCYC    = 20000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          framing_err;
  logic          overrun_err;

  uart_rx_controller #(
    .CLOCKS_PER_BIT(CPB),
    .DATA_BITS     (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .busy       (busy),
    .framing_err(framing_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  bit            in_hist[NCYC];
  bit            in_frame = 1'b0;
  int            t0 = 0;
  logic [DB-1:0] e_data = '0;
  logic          e_valid = 1'b0;
  logic          e_busy = 1'b0;
  logic          e_ferr = 1'b0;
  logic          e_oerr = 1'b0;
  logic [7:0]    got[$];
  int            ferr_cnt = 0;
  int            oerr_cnt = 0;
  int            busy_cycles = 0;
  bit            rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronised line as seen by the receiver: the input two cycles earlier, idle-high before time zero.
  function automatic bit rxs(input int k);
    if (k < 2) return 1'b1;
    return in_hist[k-2];
  endfunction

  // Model: a frame starts on a falling synced edge while idle; every sample lands at a fixed offset from it.
  always @(negedge clk) begin
    logic          rs, pv, nv, nf, no;
    logic [DB-1:0] d, nd;
    if (cyc < NCYC) in_hist[cyc] = rx;
    if (!rst_n) begin
      chk("reset rx_data", 32'(rx_data), 32'h0);
      chk("reset rx_valid", 32'(rx_valid), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset framing_err", 32'(framing_err), 32'h0);
      chk("reset overrun_err", 32'(overrun_err), 32'h0);
      in_frame = 1'b0;
      e_data = '0; e_valid = 1'b0; e_busy = 1'b0; e_ferr = 1'b0; e_oerr = 1'b0;
    end else begin
      chk("rx_data", 32'(rx_data), 32'(e_data));
      chk("rx_valid", 32'(rx_valid), 32'(e_valid));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("framing_err", 32'(framing_err), 32'(e_ferr));
      chk("overrun_err", 32'(overrun_err), 32'(e_oerr));
      if (rx_valid && rx_ready) got.push_back(8'(rx_data));
      if (framing_err) ferr_cnt++;
      if (overrun_err) oerr_cnt++;
      if (busy) busy_cycles++;

      rs = rxs(cyc);
      pv = rxs(cyc - 1);
      nv = e_valid & ~rx_ready;
      nf = 1'b0;
      no = 1'b0;
      nd = e_data;
      if (!in_frame) begin
        if (pv && !rs) begin
          in_frame = 1'b1;
          t0 = cyc;
        end
      end else if (cyc == t0 + S0 && rs) begin
        in_frame = 1'b0;
      end else if (cyc == t0 + STOP_AT) begin
        in_frame = 1'b0;
        for (int i = 0; i < DB; i++) d[i] = rxs(t0 + S0 + CPB * (i + 1));
        if (!rs) nf = 1'b1;
        else if (e_valid && !rx_ready) no = 1'b1;
        else begin
          nd = d;
          nv = 1'b1;
        end
      end
      e_data = nd; e_valid = nv; e_ferr = nf; e_oerr = no; e_busy = in_frame;
    end
  end

  task automatic tick(input logic v);
    @(posedge clk);
    #2;
    rx = v;
    if (rnd_ready) rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop_bit, input int ncyc, input bit pulse_ready);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < ncyc; k++) begin
      tick(bits[k/CPB]);
      if (pulse_ready) rx_ready = (k == 10 * CPB - 1);
    end
    if (pulse_ready) begin
      tick(1'b1);
      rx_ready = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit pulse_ready);
    send_bits(b, stop_bit, 10 * CPB, pulse_ready);
  endtask

  task automatic clr();
    got.delete();
    ferr_cnt = 0;
    oerr_cnt = 0;
    busy_cycles = 0;
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (got.size() > i) return 32'(got[i]);
    return 32'hDEAD;
  endfunction

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, len;
    logic [7:0] b;
    logic sb;

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(4);

    clr();
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(4);
    chk("a5 count", 32'(got.size()), 32'd1);
    chk("a5 data", got_at(0), 32'hA5);
    chk("a5 busy cycles", 32'(busy_cycles), 32'd77);
    chk("a5 errors", 32'(ferr_cnt + oerr_cnt), 32'd0);
    chk("a5 busy after", 32'(busy), 32'd0);

    clr();
    repeat (3) tick(1'b0);
    idle(12);
    chk("false start count", 32'(got.size()), 32'd0);
    chk("false start busy cycles", 32'(busy_cycles), 32'd5);
    chk("false start errors", 32'(ferr_cnt + oerr_cnt), 32'd0);

    clr();
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(4);
    chk("framing pulses", 32'(ferr_cnt), 32'd1);
    chk("framing no byte", 32'(got.size()), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(4);
    chk("after framing data", got_at(0), 32'h81);
    chk("after framing pulses", 32'(ferr_cnt), 32'd1);

    clr();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(4);
    chk("overrun pulses", 32'(oerr_cnt), 32'd1);
    chk("overrun held data", 32'(rx_data), 32'h11);
    chk("overrun held valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    idle(4);
    chk("overrun delivered count", 32'(got.size()), 32'd1);
    chk("overrun delivered data", got_at(0), 32'h11);

    clr();
    rx_ready = 1'b0;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1);
    chk("overlap first data", got_at(0), 32'h00);
    chk("overlap valid kept", 32'(rx_valid), 32'd1);
    chk("overlap new data", 32'(rx_data), 32'hFF);
    chk("overlap no overrun", 32'(oerr_cnt), 32'd0);
    rx_ready = 1'b1;
    idle(3);
    chk("overlap count", 32'(got.size()), 32'd2);
    chk("overlap second data", got_at(1), 32'hFF);

    clr();
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0);
    send_bits(8'h5A, 1'b1, 5 * CPB + 3, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset valid", 32'(rx_valid), 32'd0);
    chk("async reset data", 32'(rx_data), 32'd0);
    repeat (3) tick(1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rx_ready = 1'b1;
    idle(4);
    chk("reset lost byte", 32'(got.size()), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(4);
    chk("post reset count", 32'(got.size()), 32'd1);
    chk("post reset data", got_at(0), 32'h5A);

    clr();
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        len = int'($urandom_range(1, 4));
        repeat (len) tick(1'b0);
        idle(10);
      end else begin
        b  = 8'($urandom);
        sb = (r != 1);
        send_frame(b, sb, 1'b0);
        idle(sb ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 5)));
      end
    end
    rnd_ready = 1'b0;
    rx_ready = 1'b1;
    idle(6);
    chk("random drained valid", 32'(rx_valid), 32'd0);

    finish_run();
  end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
- Receive-side sequencer for the UART Rx path.
- Synchronises the serial line, detects the start-bit falling edge and drives a mid-bit sampling timer.
- Steps an IDLE/START/DATA/STOP state machine on each sampling strobe and assembles a LSB-first byte.
- Presents the byte on a valid/ready handshake to the downstream consumer; reports framing and overrun errors.

Parameters:
- CLOCKS_PER_BIT, 5000 (8 when FORMAL defined): system clocks per UART bit (48 MHz / 9600 Hz).
- DATA_BITS, 8: data bits per frame; legal range 5..8.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  raw serial line, idle high, asynchronous to clk.
- rx_data  out  DATA_BITS  received byte; stable while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready at posedge.
- busy  out  1  high whenever state != IDLE.
- framing_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err  out  1  one-cycle pulse: frame completed while previous byte unaccepted.

Behaviour:
- Reset: state IDLE; rx_data=0; rx_valid, busy, framing_err, overrun_err = 0.
- Reset: both synchroniser flops and the edge-history flop = 1; timer = 0; strobe = 0.
- Synchroniser: rx passes through 2 flops to give rx_s; all decisions use rx_s only.
- Edge detect: an edge flop holds the previous rx_s; a start edge is previous=1 and rx_s=0.
- Bit timer counter width: clog2(CLOCKS_PER_BIT).
- Bit timer in IDLE: counter held at 0, no strobe.
- Bit timer on start_pulse: counter loads CLOCKS_PER_BIT>>1.
- Bit timer otherwise: counter increments; it wraps from CLOCKS_PER_BIT-1 to 0.
- Strobe: registered; high for exactly one cycle after any cycle in which counter == CLOCKS_PER_BIT-1.
- Strobe timing, CLOCKS_PER_BIT=8: start_pulse at cycle t gives the first strobe at t+5, then one every 8 cycles.
- IDLE: on a start edge, pulse start_pulse for one cycle and go to START.
- START, at strobe: rx_s=1 is a false start; return to IDLE with no output and no error.
- START, at strobe: rx_s=0 goes to DATA with bit_idx=0.
- DATA, at strobe: shift rx_s into shift-register MSB, right-shifting (LSB first); bit_idx++.
- DATA: after the DATA_BITS-th sample, go to STOP.
- STOP, at strobe, rx_s=1: transfer shift register to rx_data; set rx_valid the next cycle; go to IDLE.
- STOP, at strobe, rx_s=0: pulse framing_err; discard byte; go to IDLE.
- Re-arm after framing error: requires rx_s to return high, which the edge rule enforces; no extra state.
- Handshake: rx_valid & rx_ready clears rx_valid on that edge. rx_data must not change while rx_valid=1 except via the overlap rule below.
- Overrun: frame completes while rx_valid=1 and rx_ready=0. Keep the old byte, drop the new one, pulse overrun_err.
- Overlap: frame completes in the same cycle the old byte is accepted. Load the new byte, rx_valid stays 1, no overrun.
- rx_ready while rx_valid=0: ignored.
- Framing error and overrun in the same frame: framing_err only; the byte is not delivered.
- Async reset mid-frame: immediate return to reset state; pending byte lost.
- Timer is a free-running modulo counter; no other arithmetic. bit_idx width: clog2(DATA_BITS+1).

Decomposition:
- Shared package uart_pkg: state enum (IDLE, START, DATA, STOP), default CLOCKS_PER_BIT and DATA_BITS constants, FORMAL override of CLOCKS_PER_BIT.
- One sub-module, uart_rx_bit_timer (ports: clk, rst_n, enable, start_pulse, bit_strobe), implementing the timer above.
- The FSM, synchroniser, shift register and handshake stay in uart_rx_controller.

Test Plan (CLOCKS_PER_BIT=8, DATA_BITS=8, rx_ready=1 unless stated):
- Clean frame for 0xA5, driven LSB first, bit period 8 clk: rx_data=0xA5, rx_valid high 1 cycle, busy low afterwards, no error pulses.
- False start (rx low 3 clk then high): no rx_valid, no errors, busy high then low before the first DATA strobe.
- Frame for 0x3C with stop bit low: framing_err pulses once, rx_valid stays 0, next valid frame 0x81 received correctly.
- rx_ready=0, frames 0x11 then 0x22: rx_data=0x11 held and overrun_err pulses at the end of the second frame. Raising rx_ready afterwards delivers 0x11 only.
- Back-to-back frames 0x00, 0xFF with no idle gap: both delivered in order. rx_ready asserted on the exact cycle of the second completion keeps rx_valid=1 with 0xFF and gives no overrun.
- rst_n pulsed low during DATA bit 4: all outputs 0 immediately. The following clean frame 0x5A is received correctly.
